// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: shared rate selects, reset FSM states and divider helper for cpu_clock_ctrl
package clk_ctrl_pkg;
    localparam logic [1:0] RATE_SLOW = 2'd0;
    localparam logic [1:0] RATE_MED  = 2'd1;
    localparam logic [1:0] RATE_FAST = 2'd2;
    localparam logic [1:0] RATE_MAX  = 2'd3;

    typedef enum logic [1:0] {HOLD, STRETCH, RUN} rst_state_t;

    // Last count value of the divider: (2**div_width >> 4*rate) - 1
    function automatic logic [31:0] div_terminal(input int div_width, input logic [1:0] rate);
        return (32'd1 << (div_width - 4 * int'(rate))) - 32'd1;
    endfunction
endpackage

// File: rtl/cpu_clock_ctrl_key_debounce.sv
// key_debounce: 2-flop synchroniser, stable-count debouncer and press pulse for one active-low key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic level_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync    <= {sync[0], ~key_raw_n};
            level_d <= level;
            press   <= level & ~level_d;
            if (sync[1] == level) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: CPU clock-enable divider, debounced keys, stretched CPU reset and tick counter.
// Define SINGLE_STEP_EN to let step_mode replace the divider with the step button.
module cpu_clock_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH       = 16,
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_HOLD_TICKS  = 2,
    parameter int STEP_KEY        = 1
) (
    input  logic                clock_in,
    input  logic                reset_in_n,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    input  logic [1:0]          rate_sel,
    input  logic                step_mode,
    output logic                cpu_ce,
    output logic                cpu_reset,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [31:0]         tick_count
);
    localparam int HW = $clog2(RST_HOLD_TICKS + 2);

    logic [1:0] rate_s1, rate_s2, rate_prev;
    logic [DIV_WIDTH-1:0] div_cnt, div_last;
    logic rate_chg, div_tick;
    rst_state_t state, state_nx;
    logic [HW-1:0] hold_cnt, hold_nx;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk      (clock_in),
            .rst_n    (reset_in_n),
            .key_raw_n(key_raw_n[i]),
            .level    (key_level[i]),
            .press    (key_press[i])
        );
    end

    always_ff @(posedge clock_in or negedge reset_in_n)
        if (!reset_in_n) begin
            rate_s1   <= '0;
            rate_s2   <= '0;
            rate_prev <= '0;
        end else begin
            rate_s1   <= rate_sel;
            rate_s2   <= rate_s1;
            rate_prev <= rate_s2;
        end

    // A rate change restarts the count and swallows the tick of that cycle
    assign div_last = DIV_WIDTH'(div_terminal(DIV_WIDTH, rate_s2));
    assign rate_chg = rate_s2 != rate_prev;
    assign div_tick = !rate_chg && div_cnt == div_last;

    always_ff @(posedge clock_in or negedge reset_in_n)
        if (!reset_in_n) div_cnt <= '0;
        else div_cnt <= (rate_chg || div_tick) ? '0 : div_cnt + 1'b1;

`ifdef SINGLE_STEP_EN
    logic [1:0] step_sync;
    always_ff @(posedge clock_in or negedge reset_in_n)
        if (!reset_in_n) step_sync <= '0;
        else step_sync <= {step_sync[0], step_mode};
    assign cpu_ce = step_sync[1] ? key_press[STEP_KEY] : div_tick;
`else
    logic unused_step;
    assign unused_step = step_mode ^ key_press[STEP_KEY];
    assign cpu_ce = div_tick;
`endif

    always_ff @(posedge clock_in or negedge reset_in_n)
        if (!reset_in_n) begin
            state    <= STRETCH;
            hold_cnt <= HW'(RST_HOLD_TICKS);
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
        end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        case (state)
            HOLD: if (!key_level[0]) begin
                state_nx = STRETCH;
                hold_nx  = HW'(RST_HOLD_TICKS);
            end
            STRETCH: begin
                hold_nx  = (div_tick && hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
                state_nx = key_level[0] ? HOLD : (hold_nx == '0) ? RUN : STRETCH;
            end
            RUN: state_nx = key_level[0] ? HOLD : RUN;
            default: state_nx = STRETCH;
        endcase
    end

    always_comb cpu_reset = state != RUN;

    always_ff @(posedge clock_in or negedge reset_in_n)
        if (!reset_in_n) tick_count <= '0;
        else tick_count <= cpu_reset ? '0 : tick_count + {31'd0, cpu_ce};
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: randomized and directed bench for cpu_clock_ctrl against a behavioural model
module tb_cpu_clock_ctrl;
    import clk_ctrl_pkg::*;
    localparam int DW = 13, NK = 2, DB = 8, HT = 2, SK = 1;

    logic clk = 1'b0, rst_n = 1'b0, step = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [1:0] rate = RATE_MAX;
    logic ce, creset;
    logic [NK-1:0] lvl, prs;
    logic [31:0] tcnt;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    cpu_clock_ctrl #(
        .DIV_WIDTH(DW), .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .RST_HOLD_TICKS(HT), .STEP_KEY(SK)
    ) dut (
        .clock_in(clk), .reset_in_n(rst_n), .key_raw_n(key_n), .rate_sel(rate), .step_mode(step),
        .cpu_ce(ce), .cpu_reset(creset), .key_level(lvl), .key_press(prs), .tick_count(tcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: inputs seen at the last two/three edges, run lengths of disagreeing key samples,
    // cycles since the divider restarted, and divider ticks counted since the reset key released.
    bit [NK-1:0] m_key_h[2];
    bit [1:0] m_rate_h[3];
    bit m_step_h[2];
    bit [NK-1:0] m_lvl, m_lvl_prev, m_prs;
    int m_run[NK];
    int unsigned m_age;
    int m_rel;
    bit m_reset;
    bit [31:0] m_cnt;

    task automatic m_clear();
        m_key_h = '{default: '0};
        m_rate_h = '{default: '0};
        m_step_h = '{default: 1'b0};
        m_lvl = '0;
        m_lvl_prev = '0;
        m_prs = '0;
        m_run = '{default: 0};
        m_age = 0;
        m_rel = 0;
        m_reset = 1'b1;
        m_cnt = '0;
    endtask

    function automatic bit m_tick_f();
        int unsigned n = (32'd1 << DW) >> (4 * int'(m_rate_h[1]));
        return m_rate_h[1] == m_rate_h[0] && (m_age % n) == n - 1;
    endfunction

    function automatic bit m_ce_f();
`ifdef SINGLE_STEP_EN
        if (m_step_h[0]) return m_prs[SK];
`endif
        return m_tick_f();
    endfunction

    task automatic m_edge();
        bit tick, pulse;
        if (!rst_n) begin
            m_clear();
            return;
        end
        tick = m_tick_f();
        pulse = m_ce_f();
        m_cnt = m_reset ? 32'd0 : m_cnt + 32'(pulse);
        if (m_lvl[0]) m_rel = -1;
        else if (m_rel < 0) m_rel = 0;
        else if (m_rel < HT) m_rel += int'(tick);
        m_reset = m_rel < HT;
        m_age = (m_rate_h[1] != m_rate_h[0]) ? 0 : m_age + 1;
        m_prs = m_lvl & ~m_lvl_prev;
        m_lvl_prev = m_lvl;
        for (int k = 0; k < NK; k++) begin
            if (m_key_h[0][k] == m_lvl[k]) m_run[k] = 0;
            else begin
                m_run[k]++;
                if (m_run[k] == DB) begin
                    m_lvl[k] = ~m_lvl[k];
                    m_run[k] = 0;
                end
            end
        end
        m_key_h[0] = m_key_h[1];
        m_key_h[1] = ~key_n;
        m_rate_h[0] = m_rate_h[1];
        m_rate_h[1] = m_rate_h[2];
        m_rate_h[2] = rate;
        m_step_h[0] = m_step_h[1];
        m_step_h[1] = step;
    endtask

    task automatic cycle();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        check("cpu_ce", 32'(ce), 32'(m_ce_f()));
        check("cpu_reset", 32'(creset), 32'(m_reset));
        check("key_level", 32'(lvl), 32'(m_lvl));
        check("key_press", 32'(prs), 32'(m_prs));
        check("tick_count", tcnt, m_cnt);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_ce(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!ce && n < 600);
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (creset && n < 200) begin
            cycle();
            n++;
        end
        check(tag, 32'(creset), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ce"}, 32'(ce), 32'd0);
        check({tag, "_reset"}, 32'(creset), 32'd1);
        check({tag, "_level"}, 32'(lvl), 32'd0);
        check({tag, "_press"}, 32'(prs), 32'd0);
        check({tag, "_count"}, tcnt, 32'd0);
    endtask

    initial begin
        int n, pulses;
        m_clear();
        #12;
        check_reset_values("por");
        run(2);
        rst_n = 1'b1;

        // Reset stretch and first ticks at the fastest rate
        n = 0;
        pulses = 0;
        while (creset && n < 100) begin
            cycle();
            n++;
            if (creset) pulses += int'(ce);
        end
        check("stretch_ticks", pulses, 2);
        check("stretch_done", 32'(creset), 32'd0);
        pulses = 0;
        n = 0;
        while (pulses < 10 && n < 100) begin
            cycle();
            n++;
            pulses += int'(ce);
        end
        cycle();
        check("ticks10", tcnt, 32'd10);

        // Rate change mid-count
        cycle();
        rate = RATE_MED;
        run(2);
        wait_ce(n);
        check("rate_restart", n, 512);
        wait_ce(n);
        check("rate_spacing", n, 512);
        rate = RATE_MAX;
        run(6);

        // Bounce, then a clean press and release of the reset key
        repeat (4) begin
            key_n[0] = 1'b0;
            run(5);
            key_n[0] = 1'b1;
            run(2);
        end
        check("bounce_level", 32'(lvl[0]), 32'd0);
        key_n[0] = 1'b0;
        pulses = 0;
        repeat (14) begin
            cycle();
            pulses += int'(prs[0]);
        end
        check("press_once", pulses, 1);
        check("held_level", 32'(lvl[0]), 32'd1);
        check("held_reset", 32'(creset), 32'd1);
        check("held_count", tcnt, 32'd0);
        key_n[0] = 1'b1;
        n = 0;
        while (lvl[0] && n < 50) begin
            cycle();
            n++;
        end
        pulses = 0;
        n = 0;
        while (creset && n < 100) begin
            cycle();
            n++;
            if (creset) pulses += int'(ce);
        end
        check("release_ticks", pulses, 2);

        // Asynchronous reset mid-run
        n = 0;
        while (tcnt != 32'd37 && n < 200) begin
            cycle();
            n++;
        end
        check("count37", tcnt, 32'd37);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        m_clear();
        run(2);
        rst_n = 1'b1;

`ifdef SINGLE_STEP_EN
        step = 1'b1;
        wait_run("step_run");
        pulses = 0;
        repeat (30) begin
            cycle();
            pulses += int'(ce);
        end
        check("step_idle", pulses, 0);
        repeat (3) begin
            key_n[SK] = 1'b0;
            repeat (14) begin
                cycle();
                pulses += int'(ce);
            end
            key_n[SK] = 1'b1;
            repeat (14) begin
                cycle();
                pulses += int'(ce);
            end
        end
        check("step_pulses", pulses, 3);
        check("step_count", tcnt, 32'd3);
        step = 1'b0;
        run(4);
`endif

        // Counter wrap
        wait_run("wrap_run");
        force dut.tick_count = 32'hFFFF_FFFE;
        #1 release dut.tick_count;
        m_cnt = 32'hFFFF_FFFE;
        wait_ce(n);
        wait_ce(n);
        cycle();
        check("wrap_zero", tcnt, 32'd0);

        // Randomized traffic on every input
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) rate = 2'($urandom_range(0, 3));
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 15) == 0) key_n[k] = ~key_n[k];
            if ($urandom_range(0, 199) == 0) step = ~step;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
